// File: rtl/lsu_pkg.sv
// lsu_pkg: types and constants shared by the data-memory load and store paths.
//   XLEN         data/address width (only 32 is supported)
//   STRB_W       write-strobe width, one bit per byte lane
//   st_width_e   funct3 encoding of the access width
//   BRESP_*      write-response codes returned on the B channel
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    ST_BYTE = 3'b000,
    ST_HALF = 3'b001,
    ST_WORD = 3'b010
  } st_width_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/store_align.sv
// store_align: combinational byte-lane formatter for stores.
//   width       funct3 of the store (SB/SH/SW, others illegal)
//   ea_lo       low two bits of the effective address
//   data        store source (rs2)
//   wdata       source replicated across the lanes it may occupy
//   wstrb       byte-enable for the addressed lanes
//   misaligned  SH on an odd address or SW not on a word boundary
//   illegal     funct3 is not a store width
module store_align
  import lsu_pkg::*;
(
  input  logic [2:0]        width,
  input  logic [1:0]        ea_lo,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              misaligned,
  output logic              illegal
);

  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (width)
      ST_BYTE: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << ea_lo;
      end
      ST_HALF: begin
        wdata      = {2{data[15:0]}};
        wstrb      = 4'b0011 << ea_lo;
        misaligned = ea_lo[0];
      end
      ST_WORD: begin
        wdata      = data;
        wstrb      = 4'b1111;
        misaligned = (ea_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one store from decode, formats it and issues a single
// write over the data-memory AW/W/B channels; at most one store outstanding.
//   clk, rst                   clock, synchronous active-high reset
//   i_en / o_ready             store request, accepted only while idle
//   i_width, i_base, i_offset  funct3, rs1, sign-extended immediate
//   i_data                     rs2 store source
//   o_done / o_err             one-cycle completion pulse and its error flag
//   o_dm_bus_aw*               write-address channel
//   o_dm_bus_w*                write-data channel
//   i_dm_bus_b*, o_dm_bus_bready  write-response channel
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a new store
// ST_SEND | AW and W in flight, each valid drops after its own handshake
// ST_RESP | both handshakes done, waiting for the write response
// ST_DONE | report completion/error for one cycle
module store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [2:0]        i_width,
  input  logic [XLEN-1:0]   i_base,
  input  logic [XLEN-1:0]   i_offset,
  input  logic [XLEN-1:0]   i_data,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic              o_dm_bus_awvalid,
  input  logic              i_dm_bus_awready,
  output logic [XLEN-1:0]   o_dm_bus_awaddr,
  output logic              o_dm_bus_wvalid,
  input  logic              i_dm_bus_wready,
  output logic [XLEN-1:0]   o_dm_bus_wdata,
  output logic [STRB_W-1:0] o_dm_bus_wstrb,
  input  logic              i_dm_bus_bvalid,
  output logic              o_dm_bus_bready,
  input  logic [1:0]        i_dm_bus_bresp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RESP,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   awaddr_q, awaddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic [XLEN-1:0]   ea;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_wstrb;
  logic              al_misaligned;
  logic              al_illegal;

  assign ea = i_base + i_offset;

  store_align u_align (
    .width      (i_width),
    .ea_lo      (ea[1:0]),
    .data       (i_data),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          if (al_misaligned || al_illegal) begin
            // Rejected stores never touch the bus.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d     = 1'b0;
            awaddr_d  = {ea[XLEN-1:2], 2'b00};
            wdata_d   = al_wdata;
            wstrb_d   = al_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (awvalid_q && i_dm_bus_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_dm_bus_wready)   wvalid_d  = 1'b0;
        // Both channels may finish in the same cycle or in different ones.
        if (!awvalid_d && !wvalid_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_dm_bus_bvalid) begin
          err_d   = (i_dm_bus_bresp != BRESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode registered state only; no input reaches an output
  // combinationally.
  assign o_ready          = (state_q == ST_IDLE);
  assign o_done           = (state_q == ST_DONE);
  assign o_err            = (state_q == ST_DONE) && err_q;
  assign o_dm_bus_bready  = (state_q == ST_RESP);
  assign o_dm_bus_awvalid = awvalid_q;
  assign o_dm_bus_wvalid  = wvalid_q;
  assign o_dm_bus_awaddr  = awaddr_q;
  assign o_dm_bus_wdata   = wdata_q;
  assign o_dm_bus_wstrb   = wstrb_q;

endmodule

// File: doc/store_unit.md
# store_unit

Write-side counterpart of the data-memory load path. It accepts one store (SB/SH/SW) per request from decode and computes the effective address. It formats byte lanes and write strobes, then drives a single transaction over the data-memory bus write-address (AW), write-data (W) and write-response (B) channels. It reports completion and error status back to the pipeline and holds at most one store outstanding.

## Interface
- XLEN, 32, data/address width; only 32 is supported, and strobe width is XLEN/8 = 4.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_en  in  1  store request; sampled only when o_ready=1
- i_width  in  3  funct3: 000=SB, 001=SH, 010=SW, all others illegal
- i_base  in  XLEN  rs1 value
- i_offset  in  XLEN  sign-extended immediate
- i_data  in  XLEN  rs2 value (store source)
- o_ready  out  1  unit idle, can accept i_en
- o_done  out  1  one-cycle pulse, store finished (success or error)
- o_err  out  1  valid with o_done: misaligned, illegal width, or bus error
- o_dm_bus_awvalid / i_dm_bus_awready / o_dm_bus_awaddr[XLEN]  write-address channel
- o_dm_bus_wvalid / i_dm_bus_wready / o_dm_bus_wdata[XLEN] / o_dm_bus_wstrb[XLEN/8]  write-data channel
- i_dm_bus_bvalid / o_dm_bus_bready / i_dm_bus_bresp[2]  write-response channel

## Operation
- States: ST_IDLE, ST_SEND, ST_RESP, ST_DONE.
- ST_IDLE: o_ready=1. On i_en:
  - Compute ea = i_base + i_offset (mod 2^XLEN).
  - If the width is illegal, or the access is misaligned (SH with ea[0]=1, SW with ea[1:0]!=0), go to ST_DONE with err=1. No bus activity.
  - Otherwise register the address, data and strobe, and go to ST_SEND.
- ST_SEND: awvalid and wvalid both asserted on entry.
  - Each valid drops independently after its own handshake (valid&ready on a rising edge).
  - When both handshakes have completed (same or different cycles), go to ST_RESP.
  - awaddr, wdata and wstrb are stable while their valid is high.
- ST_RESP: bready=1. On bvalid, capture err = (bresp!=2'b00) and go to ST_DONE.
- ST_DONE: o_done=1 and o_err=err for exactly one cycle, then ST_IDLE.
- awaddr = {ea[XLEN-1:2], 2'b00} (word-aligned).
- Lane formatting:
  - SB: wdata = {4{i_data[7:0]}}, wstrb = 4'b0001 << ea[1:0].
  - SH: wdata = {2{i_data[15:0]}}, wstrb = 4'b0011 << ea[1:0].
  - SW: wdata = i_data, wstrb = 4'b1111.
- i_en while o_ready=0 is ignored. No queuing, no error.
- bvalid arriving outside ST_RESP is ignored, since bready=0 there.

## Timing
- Reset values: o_ready=1, o_done=0, o_err=0, awvalid=0, wvalid=0, bready=0, awaddr/wdata/wstrb=0. State is ST_IDLE.
- Reset asserted mid-transaction: all valids, bready and o_done are 0 on the next edge and state is ST_IDLE. The outstanding transaction is abandoned; the bus is reset by the same rst.
- i_en at cycle 0 → awvalid and wvalid high in cycle 1.
- Zero-wait bus (ready high, bvalid in first RESP cycle): RESP in cycle 2, DONE (o_done) in cycle 3, o_ready=1 in cycle 4.
  - Minimum issue-to-done latency is 3 cycles.
  - Throughput is one store per 4 cycles.
- Error path (misaligned or illegal width): o_done=1, o_err=1 in cycle 1; o_ready=1 in cycle 2.
- o_ready is a registered decode of state, so there is no combinational path from any input to any output.

## Structure
- Shared package lsu_pkg holds:
  - the width enum (ST_BYTE=3'b000, ST_HALF=3'b001, ST_WORD=3'b010), shared with the load path;
  - the BRESP constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
- The state enum is local to the module.
- One sub-module: store_align. It is combinational: (width, ea[1:0], data) → (wdata, wstrb, misaligned, illegal). It is reused by later sub-word store logic.

## Test plan
- SW: base=0x1000, off=4, data=0xDEADBEEF, bus always ready, bvalid=1 with OKAY on the first RESP cycle.
  - Required: awaddr=0x1004, wdata=0xDEADBEEF, wstrb=1111, o_done at cycle 3, o_err=0.
- SB: ea=0x2003, data=0x000000A5.
  - Required: awaddr=0x2000, wdata=0xA5A5A5A5, wstrb=1000.
- SH misaligned (ea=0x3001) and funct3=011 (illegal width).
  - Required for each: no awvalid/wvalid, o_done=o_err=1 in cycle 1.
- Stalled bus: awready high in cycle 1, wready held low until cycle 4, bvalid with bresp=SLVERR two cycles after entering RESP.
  - Required: awvalid drops after cycle 1, wvalid stays high until the cycle-4 handshake, o_err=1.
- Protocol robustness: pulse i_en during ST_SEND, then assert rst during ST_RESP.
  - Required: the second i_en is ignored; after reset all outputs are at their reset values and o_ready=1 on the next cycle.
